// File: rtl/nfc_page_buffer_pkg.sv
// Shared types and helpers for the multi-bank NAND flash page buffer.
package nfc_buf_pkg;

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    H_FILL   = 3'd1,
    PROG_RDY = 3'd2,
    C_DRAIN  = 3'd3,
    C_FILL   = 3'd4,
    READ_RDY = 3'd5,
    H_DRAIN  = 3'd6
  } bank_state_e;

  typedef enum logic {
    DIR_HOST_FILL  = 1'b0,
    DIR_HOST_DRAIN = 1'b1
  } dir_e;

  // A single bank still needs a one-bit select so port widths stay legal.
  function automatic int calc_bank_w(input int num_banks);
    return (num_banks > 2) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/nfc_page_buffer_port.sv
// One side (host or controller) of the page buffer: active bank, direction,
// word counter, beat acceptance/error decode and rvalid/done/err pulses.
module nfc_buf_port #(
  parameter int   PAGE_DEPTH = 2048,
  parameter int   BANK_W     = 1,
  parameter logic FILL_DIR   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BANK_W-1:0]             bank,
  input  logic                          dir,
  input  logic                          we,
  input  logic                          re,
  input  logic                          grant,
  output logic                          start_acc,
  output logic                          wr_acc,
  output logic                          rd_acc,
  output logic                          last_acc,
  output logic [BANK_W-1:0]             act_bank,
  output logic [$clog2(PAGE_DEPTH)-1:0] cnt,
  output logic                          rvalid,
  output logic                          done,
  output logic                          err
);
  localparam int CNT_W = $clog2(PAGE_DEPTH);

  logic              active_r;
  logic              fill_r;
  logic [BANK_W-1:0] act_bank_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              rvalid_r;
  logic              done_r;
  logic              err_r;
  logic              err_s;

  // Any beat that is not accepted is a protocol error, as is a refused start.
  always_comb begin
    wr_acc    = active_r & fill_r & we & ~re;
    rd_acc    = active_r & ~fill_r & re & ~we;
    last_acc  = (wr_acc | rd_acc) & (cnt_r == CNT_W'(PAGE_DEPTH - 1));
    start_acc = start & ~active_r & grant;
    err_s     = (start & ~start_acc) | ((we | re) & ~(wr_acc | rd_acc));
  end

  // Ownership, counter and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r   <= 1'b0;
      fill_r     <= 1'b0;
      act_bank_r <= {BANK_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      rvalid_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      rvalid_r <= rd_acc;
      done_r   <= last_acc & ~fill_r;
      err_r    <= err_s;
      if (start_acc) begin
        active_r   <= 1'b1;
        fill_r     <= (dir == FILL_DIR);
        act_bank_r <= bank;
        cnt_r      <= {CNT_W{1'b0}};
      end else if (last_acc) begin
        active_r <= 1'b0;
        cnt_r    <= {CNT_W{1'b0}};
      end else if (wr_acc | rd_acc) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign act_bank = act_bank_r;
  assign cnt      = cnt_r;
  assign rvalid   = rvalid_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: rtl/nfc_page_buffer.sv
// Multi-bank NAND page buffer shared by the host and the flash controller under
// per-bank ownership. Optional stored word parity: define PAGE_BUF_PARITY_EN.
module nfc_page_buffer
  import nfc_buf_pkg::*;
#(
  parameter int  DATA_W     = 16,
  parameter int  PAGE_DEPTH = 2048,
  parameter int  NUM_BANKS  = 2,
  localparam int BANK_W     = calc_bank_w(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h_start,
  input  logic [BANK_W-1:0]    h_bank,
  input  logic                 h_dir,
  input  logic                 h_we,
  input  logic                 h_re,
  input  logic [DATA_W-1:0]    h_din,
  output logic [DATA_W-1:0]    h_dout,
  output logic                 h_rvalid,
  output logic                 h_done,
  output logic                 h_err,
  input  logic                 c_start,
  input  logic [BANK_W-1:0]    c_bank,
  input  logic                 c_dir,
  input  logic                 c_we,
  input  logic                 c_re,
  input  logic [DATA_W-1:0]    c_din,
  output logic [DATA_W-1:0]    c_dout,
  output logic                 c_rvalid,
  output logic                 c_done,
  output logic                 c_err,
  output logic [NUM_BANKS-1:0] prog_rdy,
  output logic [NUM_BANKS-1:0] read_rdy,
  output logic                 par_err
);
  localparam int CNT_W  = $clog2(PAGE_DEPTH);
  localparam int ADDR_W = BANK_W + CNT_W;
`ifdef PAGE_BUF_PARITY_EN
  localparam int MEM_W  = DATA_W + 1;
`else
  localparam int MEM_W  = DATA_W;
`endif

  bank_state_e          state_r [NUM_BANKS];
  logic [NUM_BANKS-1:0] prog_rdy_r;
  logic [NUM_BANKS-1:0] read_rdy_r;
  logic                 h_grant_s, c_grant_s;
  logic                 h_start_acc_s, c_start_acc_s;
  logic                 h_wr_s, h_rd_s, h_last_s;
  logic                 c_wr_s, c_rd_s, c_last_s;
  logic [BANK_W-1:0]    h_act_bank_s, c_act_bank_s;
  logic [CNT_W-1:0]     h_cnt_s, c_cnt_s;
  logic [ADDR_W-1:0]    h_addr_s, c_addr_s;
  logic [MEM_W-1:0]     mem_r [NUM_BANKS*PAGE_DEPTH];
  logic [DATA_W-1:0]    h_dout_r, c_dout_r;

  function automatic logic [MEM_W-1:0] mem_word(input logic [DATA_W-1:0] d);
`ifdef PAGE_BUF_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Host start is legal only on an EMPTY bank (fill) or a READ_RDY bank (drain).
  always_comb begin
    h_grant_s = 1'b0;
    if (int'(h_bank) < NUM_BANKS) begin
      if (h_dir == DIR_HOST_FILL) begin
        h_grant_s = (state_r[h_bank] == EMPTY);
      end else begin
        h_grant_s = (state_r[h_bank] == READ_RDY);
      end
    end else begin
      h_grant_s = 1'b0;
    end
  end

  // Controller start mirrors the host; it loses a same-bank race to the host.
  always_comb begin
    c_grant_s = 1'b0;
    if (int'(c_bank) < NUM_BANKS) begin
      if (c_dir == 1'b0) begin
        c_grant_s = (state_r[c_bank] == PROG_RDY);
      end else begin
        c_grant_s = (state_r[c_bank] == EMPTY) && !(h_start_acc_s && (h_bank == c_bank));
      end
    end else begin
      c_grant_s = 1'b0;
    end
  end

  nfc_buf_port #(.PAGE_DEPTH(PAGE_DEPTH), .BANK_W(BANK_W), .FILL_DIR(1'b0)) u_host_port (
    .clk(clk), .rst(rst), .start(h_start), .bank(h_bank), .dir(h_dir),
    .we(h_we), .re(h_re), .grant(h_grant_s), .start_acc(h_start_acc_s),
    .wr_acc(h_wr_s), .rd_acc(h_rd_s), .last_acc(h_last_s),
    .act_bank(h_act_bank_s), .cnt(h_cnt_s),
    .rvalid(h_rvalid), .done(h_done), .err(h_err)
  );

  nfc_buf_port #(.PAGE_DEPTH(PAGE_DEPTH), .BANK_W(BANK_W), .FILL_DIR(1'b1)) u_ctrl_port (
    .clk(clk), .rst(rst), .start(c_start), .bank(c_bank), .dir(c_dir),
    .we(c_we), .re(c_re), .grant(c_grant_s), .start_acc(c_start_acc_s),
    .wr_acc(c_wr_s), .rd_acc(c_rd_s), .last_acc(c_last_s),
    .act_bank(c_act_bank_s), .cnt(c_cnt_s),
    .rvalid(c_rvalid), .done(c_done), .err(c_err)
  );

  assign h_addr_s = {h_act_bank_s, h_cnt_s};
  assign c_addr_s = {c_act_bank_s, c_cnt_s};

  // Per-bank ownership FSM with registered ready flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_r[i] <= EMPTY;
      end
      prog_rdy_r <= {NUM_BANKS{1'b0}};
      read_rdy_r <= {NUM_BANKS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        case (state_r[i])
          EMPTY: begin
            if (h_start_acc_s && (h_bank == BANK_W'(i))) begin
              state_r[i] <= H_FILL;
            end else if (c_start_acc_s && (c_bank == BANK_W'(i))) begin
              state_r[i] <= C_FILL;
            end
          end
          H_FILL: begin
            if (h_last_s && (h_act_bank_s == BANK_W'(i))) begin
              state_r[i]    <= PROG_RDY;
              prog_rdy_r[i] <= 1'b1;
            end
          end
          PROG_RDY: begin
            if (c_start_acc_s && (c_bank == BANK_W'(i))) begin
              state_r[i]    <= C_DRAIN;
              prog_rdy_r[i] <= 1'b0;
            end
          end
          C_DRAIN: begin
            if (c_last_s && (c_act_bank_s == BANK_W'(i))) begin
              state_r[i] <= EMPTY;
            end
          end
          C_FILL: begin
            if (c_last_s && (c_act_bank_s == BANK_W'(i))) begin
              state_r[i]    <= READ_RDY;
              read_rdy_r[i] <= 1'b1;
            end
          end
          READ_RDY: begin
            if (h_start_acc_s && (h_bank == BANK_W'(i))) begin
              state_r[i]    <= H_DRAIN;
              read_rdy_r[i] <= 1'b0;
            end
          end
          H_DRAIN: begin
            if (h_last_s && (h_act_bank_s == BANK_W'(i))) begin
              state_r[i] <= EMPTY;
            end
          end
          default: begin
            state_r[i]    <= EMPTY;
            prog_rdy_r[i] <= 1'b0;
            read_rdy_r[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Dual-port page storage; the two ports never own the same bank.
  always_ff @(posedge clk) begin
    if (h_wr_s) mem_r[h_addr_s] <= mem_word(h_din);
    if (c_wr_s) mem_r[c_addr_s] <= mem_word(c_din);
  end

  // Registered read data, one cycle after each accepted read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_dout_r <= {DATA_W{1'b0}};
      c_dout_r <= {DATA_W{1'b0}};
    end else begin
      if (h_rd_s) h_dout_r <= mem_r[h_addr_s][DATA_W-1:0];
      if (c_rd_s) c_dout_r <= mem_r[c_addr_s][DATA_W-1:0];
    end
  end

`ifdef PAGE_BUF_PARITY_EN
  logic par_err_r;

  function automatic logic par_bad(input logic [MEM_W-1:0] w);
    return ^w;
  endfunction

  // Stored word plus its even-parity bit must XOR to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= (h_rd_s && par_bad(mem_r[h_addr_s])) || (c_rd_s && par_bad(mem_r[c_addr_s]));
    end
  end

  assign par_err = par_err_r;
`else
  assign par_err = 1'b0;
`endif

  assign h_dout   = h_dout_r;
  assign c_dout   = c_dout_r;
  assign prog_rdy = prog_rdy_r;
  assign read_rdy = read_rdy_r;

endmodule
